// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 scan timing constants, capture geometry and small helpers
// used by the sync generator, pixel fetcher and frame capture blocks.
package vga_timing_pkg;

    localparam int H_SYNC  = 128;
    localparam int H_BP    = 88;
    localparam int H_ACT   = 800;
    localparam int H_FP    = 40;
    localparam int V_SYNC  = 4;
    localparam int V_BP    = 23;
    localparam int V_ACT   = 600;
    localparam int V_FP    = 1;
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    // Counter value immediately preceding the first active column / row
    localparam int HACT0   = H_SYNC + H_BP;
    localparam int VACT0   = V_SYNC + V_BP;

    localparam int FRAME_X = 128;
    localparam int FRAME_Y = 128;
    localparam int CNT_W   = 11;
    localparam int ADDR_W  = 11;
    localparam int DATA_W  = 8;
    localparam int RGB_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_e;

    // Any lit colour channel counts as a foreground pixel
    function automatic logic pixel_on(input logic [RGB_W-1:0] rgb);
        return |rgb;
    endfunction

endpackage

// File: rtl/vga_pixel_window.sv
// Combinational capture-window decode: turns the shared c1/c2 scan counters
// into a window-valid flag and window-relative x/y coordinates.
module vga_pixel_window
    import vga_timing_pkg::*;
#(
    parameter int _X     = FRAME_X,
    parameter int _Y     = FRAME_Y,
    parameter int _XOFF  = 0,
    parameter int _YOFF  = 0,
    parameter int _HACT0 = HACT0,
    parameter int _VACT0 = VACT0,
    parameter int XW     = $clog2(_X),
    parameter int YW     = $clog2(_Y)
) (
    input  logic [CNT_W-1:0] c1,
    input  logic [CNT_W-1:0] c2,
    output logic             valid,
    output logic [XW-1:0]    x,
    output logic [YW-1:0]    y
);

    localparam logic [CNT_W-1:0] X_LO = CNT_W'(_HACT0 + _XOFF);
    localparam logic [CNT_W-1:0] X_HI = CNT_W'(_HACT0 + _XOFF + _X);
    localparam logic [CNT_W-1:0] Y_LO = CNT_W'(_VACT0 + _YOFF);
    localparam logic [CNT_W-1:0] Y_HI = CNT_W'(_VACT0 + _YOFF + _Y);

    // Half-open on the low side: the counter value X_LO itself is still blanking
    assign valid = (c1 > X_LO) && (c1 <= X_HI) && (c2 > Y_LO) && (c2 <= Y_HI);

    // Differences are formed at counter width, then cut down to coordinate width
    assign x = XW'(c1 - X_LO - CNT_W'(1));
    assign y = YW'(c2 - Y_LO - CNT_W'(1));

endmodule

// File: rtl/vga_frame_capture.sv
// Single-frame monochrome capture: samples the rgb stream inside the window,
// packs eight pixels per byte (leftmost pixel in bit 0) and writes the frame RAM.
module vga_frame_capture
    import vga_timing_pkg::*;
#(
    parameter int _X     = FRAME_X,
    parameter int _Y     = FRAME_Y,
    parameter int _XOFF  = 0,
    parameter int _YOFF  = 0,
    parameter int _HACT0 = HACT0,
    parameter int _VACT0 = VACT0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CNT_W-1:0]  c1,
    input  logic [CNT_W-1:0]  c2,
    input  logic [RGB_W-1:0]  rgb_in,
    input  logic              capture_req,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata
);

    localparam int XW  = $clog2(_X);
    localparam int YW  = $clog2(_Y);
    localparam int BPR = _X / 8;
    localparam logic [ADDR_W-1:0] BPR_A     = ADDR_W'(BPR);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BPR * _Y - 1);

    logic              win_valid_s;
    logic [XW-1:0]     win_x_s;
    logic [YW-1:0]     win_y_s;
    logic              pix_s;
    logic [2:0]        bit_sel_s;
    logic              frame_start_s;
    logic [ADDR_W-1:0] wr_addr_s;

    cap_state_e        state_q, state_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    vga_pixel_window #(
        ._X     (_X),
        ._Y     (_Y),
        ._XOFF  (_XOFF),
        ._YOFF  (_YOFF),
        ._HACT0 (_HACT0),
        ._VACT0 (_VACT0),
        .XW     (XW),
        .YW     (YW)
    ) u_window (
        .c1    (c1),
        .c2    (c2),
        .valid (win_valid_s),
        .x     (win_x_s),
        .y     (win_y_s)
    );

    assign pix_s         = pixel_on(rgb_in);
    assign bit_sel_s     = win_x_s[2:0];
    assign frame_start_s = win_valid_s && (win_x_s == '0) && (win_y_s == '0);
    assign wr_addr_s     = ADDR_W'(win_y_s) * BPR_A + ADDR_W'(win_x_s[XW-1:3]);

    // Next-state, packing and write-port decode
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (capture_req && !abort) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                // Only the very first window pixel starts a capture, so a
                // request landing mid-frame waits for the next frame
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (frame_start_s) begin
                    state_d         = ST_CAPTURE;
                    sr_d[bit_sel_s] = pix_s;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (win_valid_s) begin
                    sr_d[bit_sel_s] = pix_s;
                    if (bit_sel_s == 3'd7) begin
                        we_d    = 1'b1;
                        addr_d  = wr_addr_s;
                        wdata_d = {pix_s, sr_q[DATA_W-2:0]};
                        if (wr_addr_s == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_CAPTURE;
                        end
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule
